// File: rtl/serv_mul_seq.sv
// ============================================================================
// Module   : serv_mul_seq
// Brief    : Iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU)
//            behind a valid/ready-pulse MDU port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serv_mul_seq #(
    parameter     RESET_STRATEGY = "MINI",
    parameter int STEP_BITS      = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mdu_valid,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output logic        o_mdu_ready,
    output logic [31:0] o_rd,
    output logic        o_busy
);

    localparam int         c_N      = 32 / STEP_BITS;
    localparam logic [4:0] c_LAST   = 5'(c_N - 1);
    localparam bit         c_RST_DP = (RESET_STRATEGY != "NONE");

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_FIX  = 3'd2,
        S_RESP = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_rd;
    logic        r_neg;
    logic        r_hi;

    logic        w_accept;
    logic        w_s1;
    logic        w_s2;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [63:0] w_pp;
    logic [63:0] w_fix;

    // Operand conditioning: only the signed variants look at the sign bits
    always_comb begin
        w_accept = i_mdu_valid & ~i_funct3[2];
        w_s1     = ((i_funct3 == 3'd1) || (i_funct3 == 3'd2)) & i_rs1[31];
        w_s2     = (i_funct3 == 3'd1) & i_rs2[31];
        w_mag1   = w_s1 ? -i_rs1 : i_rs1;
        w_mag2   = w_s2 ? -i_rs2 : i_rs2;
    end

    always_comb begin
        w_pp = '0;
        for (int j = 0; j < STEP_BITS; j++) begin
            if (r_mplier[j]) begin
                w_pp = w_pp + (r_mcand << j);
            end
        end
        w_fix = r_neg ? (~r_acc + 64'd1) : r_acc;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept)         w_next = S_CALC;
            S_CALC: if (r_cnt == c_LAST)  w_next = S_FIX;
            S_FIX:                        w_next = S_RESP;
            S_RESP:                       w_next = i_mdu_valid ? S_HOLD : S_IDLE;
            S_HOLD: if (!i_mdu_valid)     w_next = S_IDLE;
            default:                      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_CALC) ? r_cnt + 5'd1 : 5'd0;
        end
    end

    // Datapath; reset may be skipped entirely for a smaller implementation
    always_ff @(posedge i_clk) begin
        if (c_RST_DP && i_rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rd     <= '0;
            r_neg    <= 1'b0;
            r_hi     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc    <= '0;
                        r_mcand  <= {32'd0, w_mag1};
                        r_mplier <= w_mag2;
                        r_neg    <= w_s1 ^ w_s2;
                        r_hi     <= (i_funct3 != 3'd0);
                    end
                end
                S_CALC: begin
                    r_acc    <= r_acc + w_pp;
                    r_mcand  <= r_mcand << STEP_BITS;
                    r_mplier <= r_mplier >> STEP_BITS;
                end
                S_FIX: begin
                    r_acc <= w_fix;
                    r_rd  <= r_hi ? w_fix[63:32] : w_fix[31:0];
                end
                default: ;
            endcase
        end
    end

    assign o_mdu_ready = (r_state == S_RESP);
    assign o_busy      = (r_state == S_CALC) || (r_state == S_FIX);
    assign o_rd        = r_rd;

endmodule

`default_nettype wire

// File: tb/tb_serv_mul_seq.sv
// ============================================================================
// Module   : tb_serv_mul_seq
// Brief    : Directed and randomized checks of serv_mul_seq at STEP_BITS 1/2/4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serv_mul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [2:0]  rdy;
    logic [2:0]  busy;
    logic [31:0] rd [3];

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] got_rd [3];
    int          got_lat [3];
    int          got_pulses [3];
    int          exp_lat [3] = '{34, 18, 10};

    always #5 clk = ~clk;

    serv_mul_seq #(.RESET_STRATEGY("MINI"), .STEP_BITS(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_mdu_valid(valid), .i_funct3(funct3),
        .i_rs1(rs1), .i_rs2(rs2), .o_mdu_ready(rdy[0]), .o_rd(rd[0]), .o_busy(busy[0]));

    serv_mul_seq #(.RESET_STRATEGY("MINI"), .STEP_BITS(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_mdu_valid(valid), .i_funct3(funct3),
        .i_rs1(rs1), .i_rs2(rs2), .o_mdu_ready(rdy[1]), .o_rd(rd[1]), .o_busy(busy[1]));

    serv_mul_seq #(.RESET_STRATEGY("NONE"), .STEP_BITS(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_mdu_valid(valid), .i_funct3(funct3),
        .i_rs1(rs1), .i_rs2(rs2), .o_mdu_ready(rdy[2]), .o_rd(rd[2]), .o_busy(busy[2]));

    function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f);
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] p;
        x = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        y = (f == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p = x * y;
        return (f == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic count_pulses(input int cyc);
        for (int k = 0; k < 3; k++) begin
            if (rdy[k]) begin
                got_pulses[k]++;
                if (got_lat[k] < 0) begin
                    got_lat[k] = cyc;
                    got_rd[k]  = rd[k];
                end
            end
        end
    endtask

    // Raise valid, wait for every instance to respond, keep valid up for
    // 'hold' extra cycles, then drop it and let the DUTs return to IDLE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f, input int hold);
        int cyc;
        bit done;
        for (int k = 0; k < 3; k++) begin
            got_lat[k] = -1;
            got_pulses[k] = 0;
            got_rd[k] = '0;
        end
        rs1 = a; rs2 = b; funct3 = f; valid = 1'b1;
        cyc = 0; done = 1'b0;
        while (!done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom_range(0, 3));
            end
            count_pulses(cyc);
            done = (got_lat[0] >= 0) && (got_lat[1] >= 0) && (got_lat[2] >= 0);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            cyc++;
            count_pulses(cyc);
        end
        valid = 1'b0;
        @(posedge clk); #1;
        count_pulses(cyc + 1);
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (rdy !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ready: got %b expected 000", rdy);
        end
        vectors++;
        if (busy !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_busy: got %b expected 000", busy);
        end
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (rd[k] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_rd[%0d]: got %h expected 00000000", k, rd[k]);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mulhu();
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 0);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (got_rd[k] !== 32'hFFFFFFFE) begin
                miscompares++;
                $display("FAIL mulhu_rd[%0d]: got %h expected fffffffe", k, got_rd[k]);
            end
            vectors++;
            if (got_lat[k] != exp_lat[k]) begin
                miscompares++;
                $display("FAIL mulhu_latency[%0d]: got %0d expected %0d", k, got_lat[k], exp_lat[k]);
            end
        end
    endtask

    task automatic test_mul_mulh();
        run_op(32'h80000000, 32'h80000000, 3'd0, 0);
        vectors++;
        if (got_rd[0] !== 32'h00000000) begin
            miscompares++;
            $display("FAIL mul_min: got %h expected 00000000", got_rd[0]);
        end
        run_op(32'h80000000, 32'h80000000, 3'd1, 0);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (got_rd[k] !== 32'h40000000) begin
                miscompares++;
                $display("FAIL mulh_min[%0d]: got %h expected 40000000", k, got_rd[k]);
            end
        end
    endtask

    task automatic test_mulhsu();
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 0);
        vectors++;
        if (got_rd[0] !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL mulhsu_neg1: got %h expected ffffffff", got_rd[0]);
        end
        run_op(32'hFFFFFFFE, 32'h00000000, 3'd2, 0);
        vectors++;
        if (got_rd[0] !== 32'h00000000) begin
            miscompares++;
            $display("FAIL mulhsu_zero: got %h expected 00000000", got_rd[0]);
        end
    endtask

    task automatic test_hold_valid();
        run_op(32'd7, 32'hFFFFFFFD, 3'd0, 20);
        vectors++;
        if (got_rd[0] !== 32'hFFFFFFEB) begin
            miscompares++;
            $display("FAIL hold_rd: got %h expected ffffffeb", got_rd[0]);
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (got_pulses[k] != 1) begin
                miscompares++;
                $display("FAIL hold_pulses[%0d]: got %0d expected 1", k, got_pulses[k]);
            end
        end
        vectors++;
        if (rd[0] !== 32'hFFFFFFEB) begin
            miscompares++;
            $display("FAIL hold_rd_stable: got %h expected ffffffeb", rd[0]);
        end
        run_op(32'd100, 32'd100, 3'd0, 0);
        vectors++;
        if (got_lat[0] != 34 || got_rd[0] !== 32'd10000) begin
            miscompares++;
            $display("FAIL back_to_back: got lat %0d rd %h expected lat 34 rd 00002710",
                     got_lat[0], got_rd[0]);
        end
    endtask

    task automatic test_reset_mid_calc();
        int pulses;
        rs1 = 32'd123; rs2 = 32'd456; funct3 = 3'd0; valid = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        vectors++;
        if (busy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL midcalc_busy: got %b expected 1", busy[0]);
        end
        rst = 1'b1; valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 3'b000 || rdy !== 3'b000) begin
            miscompares++;
            $display("FAIL midcalc_reset: got busy %b ready %b expected 000 000", busy, rdy);
        end
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (rdy != 3'b000) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL midcalc_no_ready: got %0d pulses expected 0", pulses);
        end
        run_op(32'd3, 32'd5, 3'd0, 0);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (got_rd[k] !== 32'd15 || got_lat[k] != exp_lat[k]) begin
                miscompares++;
                $display("FAIL after_reset[%0d]: got rd %h lat %0d expected rd 0000000f lat %0d",
                         k, got_rd[k], got_lat[k], exp_lat[k]);
            end
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h00000000;
            1: return 32'h00000001;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] exp_v;
        for (int i = 0; i < 1000; i++) begin
            a = pick_operand();
            b = pick_operand();
            f = 3'($urandom_range(0, 3));
            exp_v = golden(a, b, f);
            run_op(a, b, f, 0);
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (got_rd[k] !== exp_v || got_lat[k] != exp_lat[k]) begin
                    miscompares++;
                    $display("FAIL random[%0d] dut%0d f%0d %h*%h: got rd %h lat %0d expected rd %h lat %0d",
                             i, k, f, a, b, got_rd[k], got_lat[k], exp_v, exp_lat[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mulhu();
        test_mul_mulh();
        test_mulhsu();
        test_hold_valid();
        test_reset_mid_calc();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serv_mul_seq.md
Name: serv_mul_seq

Overview:
- Sequential RV32M multiply unit on the MDU extension port, downstream of the state/control block.
- Consumes the `mdu_valid` strobe plus parallel rs1/rs2/funct3.
- Returns a 32-bit rd value with a one-cycle `mdu_ready` pulse. That pulse triggers the RF write request for stage two.
- Shift-add iterative datapath: MUL, MULH, MULHSU, MULHU. Division is out of scope (funct3[2]=1 is not accepted).

Parameters:
- RESET_STRATEGY, "MINI", "NONE" skips reset on datapath regs (acc, operands); control state and o_mdu_ready are always reset.
- STEP_BITS, 1, multiplier bits retired per cycle; legal 1, 2, 4; iteration count N = 32/STEP_BITS.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_mdu_valid  in  1  request; held high by upstream until after o_mdu_ready
- i_funct3  in  3  0=MUL 1=MULH 2=MULHSU 3=MULHU
- i_rs1  in  32  multiplicand
- i_rs2  in  32  multiplier
- o_mdu_ready  out  1  one-cycle pulse; o_rd valid in same cycle
- o_rd  out  32  result
- o_busy  out  1  high in CALC and FIX

Behaviour:
- States: IDLE, CALC, FIX, RESP, HOLD.
- Reset values: state=IDLE, o_mdu_ready=0, o_busy=0, iteration counter=0. If RESET_STRATEGY!="NONE", also o_rd=0 and acc=0.
- IDLE:
  - On i_mdu_valid & !i_funct3[2]: capture funct3, then go to CALC.
  - rs1 signed for MULH/MULHSU; rs2 signed for MULH only.
  - Capture magnitudes |rs1| and |rs2| (32-bit unsigned; 0x80000000 stays 0x80000000).
  - Capture neg = sign(rs1) ^ sign(rs2) over the operands treated as signed.
  - Clear the 64-bit accumulator.
- IDLE with i_mdu_valid & i_funct3[2]: not accepted, stay IDLE. No response; the integration guarantees this does not occur.
- CALC:
  - Each cycle, add mcand shifted by the low STEP_BITS of mplier, LSB first, into the acc (acc holds the product-in-progress).
  - Shift mplier right by STEP_BITS.
  - The counter runs 0..N-1; at N-1 go to FIX.
- FIX:
  - If neg, acc = two's-complement of the 64-bit acc; else unchanged.
  - o_rd = acc[31:0] for MUL, acc[63:32] otherwise.
  - Go to RESP.
- RESP:
  - o_mdu_ready=1 for exactly this cycle; o_rd stable.
  - Go to HOLD.
- HOLD:
  - Stay while i_mdu_valid=1; return to IDLE on the first cycle i_mdu_valid=0.
  - No new request can start from HOLD. This prevents a restart from a valid that is still asserted after ready.
- Latency: request sampled at cycle T -> o_mdu_ready at T+N+2 (T+34 for STEP_BITS=1, T+10 for STEP_BITS=4).
- o_rd holds its value until the next FIX. It is the only result storage; upstream may sample it in the RESP cycle or any cycle afterwards.
- Operands are sampled only in the IDLE acceptance cycle. Changes to rs1/rs2/funct3 later have no effect.
- Timing of i_mdu_valid drop:
  - A drop during CALC/FIX is ignored; the operation completes and ready still pulses.
  - A drop in the RESP cycle is legal and returns IDLE->IDLE next.
- i_rst in any state: next cycle IDLE, o_mdu_ready=0, o_busy=0. The in-flight result is discarded and no ready pulse is issued.
- Width rules:
  - acc 64 bits; additions are 64-bit and wrap modulo 2^64.
  - Negation is 64-bit.
  - MULHSU with negative rs1 and rs2=0 must give 0 (negating zero).

Test Plan:
- MULHU: rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> o_rd=0xFFFFFFFE, ready exactly 34 cycles after the valid-sample cycle (STEP_BITS=1).
- MUL and MULH: rs1=0x80000000, rs2=0x80000000 -> MUL o_rd=0x00000000, MULH o_rd=0x40000000.
- MULHSU, negative rs1:
  - rs1=0xFFFFFFFF (-1), rs2=0xFFFFFFFF -> o_rd=0xFFFFFFFF.
  - rs1=0xFFFFFFFE, rs2=0 -> o_rd=0x00000000.
- MUL: rs1=7, rs2=-3 (0xFFFFFFFD) -> o_rd=0xFFFFFFEB. Hold valid high 20 cycles past ready -> exactly one ready pulse, no restart. Drop valid -> the next request is accepted the following cycle.
- Reset mid-CALC: assert i_rst at iteration 10 -> no ready pulse, o_busy=0 next cycle. A fresh MUL 3*5 then yields 15 with normal latency.
- Regression per STEP_BITS in {1,2,4}, 1000 random operand/funct3 pairs vs golden 64-bit model -> all match; latency is 34, 18 and 10 cycles respectively.
